// File: rtl/font_arb_pkg.sv
// Shared constants and types for the font ROM arbiter.
// The FONT_ARB_FIXED_PRIO_EN build changes arbitration only.
package font_arb_pkg;

    localparam int FONT_ADDR_W = 11;
    localparam int FONT_DATA_W = 8;
    localparam int ROM_LAT     = 1;
    localparam int ARB_LAT     = 3;

    // Wide enough to index up to 8 requesters
    typedef logic [2:0] req_idx_t;

endpackage

// File: rtl/font_rom_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping past the top back to index 0.
module rr_picker
    import font_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  req_idx_t     ptr,
    output logic [N-1:0] onehot,
    output req_idx_t     idx,
    output logic         any
);

    int j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && req[j]) begin
                any       = 1'b1;
                idx       = req_idx_t'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/font_rom_arbiter.sv
// Shares one synchronous font ROM among N_REQ text generators with a
// fixed 3-cycle tagged return. Build option: FONT_ARB_FIXED_PRIO_EN.
module font_rom_arbiter
    import font_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = FONT_ADDR_W,
    parameter int DATA_W = FONT_DATA_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [DATA_W-1:0]       rom_data,
    output logic [DATA_W-1:0]       rdata,
    output logic [N_REQ-1:0]        rvalid
);

    req_idx_t         ptr;
    req_idx_t         ptr_nxt;
    req_idx_t         pick_idx;
    req_idx_t         win;
    req_idx_t         tag1;
    req_idx_t         tag2;
    logic [N_REQ-1:0] pick_req;
    logic [N_REQ-1:0] pick_oh;
    logic [N_REQ-1:0] win_oh;
    logic [N_REQ-1:0] rv_nxt;
    logic             pick_any;
    logic             any;
    logic             upd;
    logic             v1;
    logic             v2;

`ifdef FONT_ARB_FIXED_PRIO_EN
    // Requester 0 preempts; the rest rotate over 1..N_REQ-1
    localparam req_idx_t PTR_MIN = req_idx_t'(1);
    assign pick_req = req & ~{{(N_REQ-1){1'b0}}, 1'b1};
`else
    localparam req_idx_t PTR_MIN = req_idx_t'(0);
    assign pick_req = req;
`endif

    rr_picker #(
        .N(N_REQ)
    ) u_pick (
        .req   (pick_req),
        .ptr   (ptr),
        .onehot(pick_oh),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        win    = pick_idx;
        win_oh = pick_oh;
        any    = pick_any;
        upd    = pick_any;
`ifdef FONT_ARB_FIXED_PRIO_EN
        if (req[0]) begin
            win       = '0;
            win_oh    = '0;
            win_oh[0] = 1'b1;
            any       = 1'b1;
            upd       = 1'b0;
        end
`endif
    end

    assign gnt = reset ? '0 : win_oh;

    always_comb begin
        ptr_nxt = win + req_idx_t'(1);
        if (int'(win) == N_REQ - 1) begin
            ptr_nxt = PTR_MIN;
        end
    end

    always_comb begin
        rv_nxt = '0;
        if (v2) begin
            rv_nxt[tag2] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr      <= PTR_MIN;
            rom_addr <= '0;
            tag1     <= '0;
            tag2     <= '0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            rdata    <= '0;
            rvalid   <= '0;
        end else begin
            v1 <= any;
            if (any) begin
                rom_addr <= req_addr[int'(win)*ADDR_W +: ADDR_W];
                tag1     <= win;
            end
            if (upd) begin
                ptr <= ptr_nxt;
            end
            tag2 <= tag1;
            v2   <= v1;
            // rdata only moves for a live entry
            if (v2) begin
                rdata <= rom_data;
            end
            rvalid <= rv_nxt;
        end
    end

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Scoreboard bench for font_rom_arbiter with a behavioural 1-cycle font ROM.
// Expectations follow the build selected by FONT_ARB_FIXED_PRIO_EN.
module tb_font_rom_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [43:0] req_addr;
    logic [3:0]  gnt;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  rdata;
    logic [3:0]  rvalid;

    logic [10:0] a [4];
    int total;
    int bad;
    int cyc;

    typedef struct {
        logic [3:0] oh;
        logic [7:0] d;
        int         c;
    } exp_t;
    exp_t q[$];

    font_rom_arbiter #(
        .N_REQ(4), .ADDR_W(11), .DATA_W(8)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
        .gnt(gnt), .rom_addr(rom_addr), .rom_data(rom_data),
        .rdata(rdata), .rvalid(rvalid)
    );

    assign req_addr = {a[3], a[2], a[1], a[0]};

    function automatic logic [7:0] rom_f(input logic [10:0] ad);
        return ad[7:0] ^ {5'b0, ad[10:8]} ^ 8'h5A;
    endfunction

    always @(posedge clk) rom_data <= rom_f(rom_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        total++;
        if (act !== ex) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, act, ex, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && rvalid != 4'b0) begin
            if (q.size() == 0) begin
                chk("spurious_rvalid", {28'b0, rvalid}, 32'h0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rvalid", {28'b0, rvalid}, {28'b0, e.oh});
                chk("rdata", {24'b0, rdata}, {24'b0, e.d});
                chk("latency_cycle", cyc, e.c);
            end
        end
    end

    // Drive one cycle starting just after a rising edge
    task automatic step(input logic [3:0] r, input logic [3:0] eg, input bit push = 1'b1);
        exp_t e;
        req = r;
        @(negedge clk);
        chk("gnt", {28'b0, gnt}, {28'b0, eg});
        if (eg != 4'b0 && push) begin
            for (int i = 0; i < 4; i++) begin
                if (eg[i]) begin
                    e.oh = eg;
                    e.d  = rom_f(a[i]);
                    e.c  = cyc + 3;
                end
            end
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        req   = 4'b0;
        a[0] = 11'h450; a[1] = 11'h000; a[2] = 11'h000; a[3] = 11'h000;
        repeat (2) @(posedge clk);
        #1;
        req = 4'b0001;
        @(negedge clk);
        chk("gnt_in_reset", {28'b0, gnt}, 32'h0);
        chk("rst_rom_addr", {21'b0, rom_addr}, 32'h0);
        chk("rst_rdata", {24'b0, rdata}, 32'h0);
        chk("rst_rvalid", {28'b0, rvalid}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        req   = 4'b0;

        // Single request with 3-cycle return
        step(4'b0001, 4'b0001);
        chk("rom_addr_c1", {21'b0, rom_addr}, 32'h450);
        repeat (4) step(4'b0000, 4'b0000);

        // Bring ptr back to 0 (1 in the fixed build)
        a[3] = 11'h3F0;
        step(4'b1000, 4'b1000);

        // All requesting
        a[0] = 11'h100; a[1] = 11'h200; a[2] = 11'h300; a[3] = 11'h400;
`ifdef FONT_ARB_FIXED_PRIO_EN
        repeat (8) step(4'b1111, 4'b0001);
`else
        for (int k = 0; k < 8; k++) step(4'b1111, 4'(1 << (k % 4)));
`endif
        repeat (3) step(4'b0000, 4'b0000);

        // Grant requester 1 leaves ptr=2, so 3 wins over 1
`ifdef FONT_ARB_FIXED_PRIO_EN
        step(4'b1000, 4'b1000);
`endif
        step(4'b0010, 4'b0010);
        step(4'b1010, 4'b1000);
        step(4'b1010, 4'b0010);
        repeat (3) step(4'b0000, 4'b0000);

        // Reset while a grant is in flight
        a[2] = 11'h2AB;
        step(4'b0100, 4'b0100, 1'b0);
        reset = 1'b1;
        req   = 4'b0;
        #1;
        chk("midrst_rom_addr", {21'b0, rom_addr}, 32'h0);
        chk("midrst_rdata", {24'b0, rdata}, 32'h0);
        chk("midrst_rvalid", {28'b0, rvalid}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) step(4'b0000, 4'b0000);
        chk("post_rst_rdata", {24'b0, rdata}, 32'h0);
        step(4'b1111, 4'b0001);

        // Idle hold after grant to 0x4C0
        a[2] = 11'h4C0;
        step(4'b0100, 4'b0100);
        for (int k = 0; k < 10; k++) begin
            step(4'b0000, 4'b0000);
            chk("idle_rom_addr", {21'b0, rom_addr}, 32'h4C0);
        end
        step(4'b1010, 4'b1000);

        // Single requester every cycle
        a[1] = 11'h0A5;
        repeat (3) step(4'b0010, 4'b0010);

        // 0 and 2 together
        a[0] = 11'h111; a[2] = 11'h622;
`ifdef FONT_ARB_FIXED_PRIO_EN
        step(4'b1000, 4'b1000);
        repeat (6) step(4'b0101, 4'b0001);
`else
        step(4'b1000, 4'b1000);
        for (int k = 0; k < 6; k++) step(4'b0101, (k % 2 == 0) ? 4'b0001 : 4'b0100);
`endif

        req = 4'b0;
        for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
        #1;
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
